// File: rtl/datapath_p2_pkg.sv
// Shared definitions for the phase-2 single-bus CPU datapath: instruction field
// positions, opcode constants, memory sizing, bus-source encoding and the
// C-constant sign-extension helper.
package datapath_p2_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned NUM_REGS  = 16;
   localparam int unsigned MEM_DEPTH = 512;
   localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

   // Instruction field positions
   localparam int unsigned RA_MSB  = 26;
   localparam int unsigned RB_MSB  = 22;
   localparam int unsigned RC_MSB  = 18;
   localparam int unsigned C_WIDTH = 19;
   localparam int unsigned CON_MSB = 20;

   typedef enum logic [4:0] {
      OpLd   = 5'b00000,
      OpLdi  = 5'b00001,
      OpSt   = 5'b00010,
      OpAdd  = 5'b00011,
      OpSub  = 5'b00100,
      OpAnd  = 5'b00101,
      OpAddi = 5'b01100
   } opcode_e;

   // Bus sources, listed from highest to lowest priority
   typedef enum logic [3:0] {
      SrcNone,
      SrcReg,
      SrcHi,
      SrcLo,
      SrcZhi,
      SrcZlo,
      SrcPc,
      SrcMdr,
      SrcInPort,
      SrcC
   } bus_src_e;

   function automatic logic [DATA_W-1:0] sext_c(input logic [DATA_W-1:0] ir);
      return {{(DATA_W - C_WIDTH){ir[C_WIDTH-1]}}, ir[C_WIDTH-1:0]};
   endfunction

endpackage

// File: rtl/datapath_p2_if.sv
// Control/data bundle between the control unit (or bench) and the datapath.
//   master : drives bus-source selects, load enables, ALU selects, memory
//            controls, Mdatain and InPort_in; observes outp.
//   slave  : the datapath side.
interface datapath_p2_if;
   import datapath_p2_pkg::*;

   // Bus source selects
   logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
   // Register load enables
   logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
   // ALU selects
   logic IncPC, SUB, AND_op, ADD;
   // Memory controls
   logic Read, Write, ReadEn;
   // Select/encode controls
   logic Gra, Grb, Grc, Rin, Rout, BAout;
   // Misc
   logic Cout, CONIn, Strobe;
   logic [DATA_W-1:0] Mdatain, InPort_in, outp;

   modport master (
      output PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
      output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
      output IncPC, SUB, AND_op, ADD, Read, Write, ReadEn,
      output Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe,
      output Mdatain, InPort_in,
      input  outp
   );

   modport slave (
      input  PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
      input  IncPC, SUB, AND_op, ADD, Read, Write, ReadEn,
      input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe,
      input  Mdatain, InPort_in,
      output outp
   );

endinterface

// File: rtl/datapath_p2_reg32.sv
// Load-enable register with asynchronous active-low clear.
//   clk_i  : clock          rst_ni : async clear (active low)
//   ld_i   : load enable    d_i    : data in      q_o : contents
module datapath_p2_reg32 #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ld_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] q_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else if (ld_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/datapath_p2_select_encode.sv
// Select-and-encode: picks a register index from the IR Ra/Rb/Rc fields and
// turns Rin/Rout/BAout into a one-hot load vector and bus-drive controls.
//   ir_i       : IR[26:15] (Ra, Rb, Rc fields)
//   gra/grb/grc_i : field gates    rin/rout/baout_i : register strobes
//   reg_idx_o  : selected register  rin_o : one-hot load enables
//   drive_o    : register file drives the bus
//   zero_o     : drive constant 0 instead (BAout with R0)
module datapath_p2_select_encode
   import datapath_p2_pkg::*;
(
   input  logic [RA_MSB:RC_MSB-3] ir_i,
   input  logic                   gra_i,
   input  logic                   grb_i,
   input  logic                   grc_i,
   input  logic                   rin_i,
   input  logic                   rout_i,
   input  logic                   baout_i,
   output logic [3:0]             reg_idx_o,
   output logic [NUM_REGS-1:0]    rin_o,
   output logic                   drive_o,
   output logic                   zero_o
);

   logic [3:0] ra, rb, rc;

   assign ra = ir_i[RA_MSB -: 4];
   assign rb = ir_i[RB_MSB -: 4];
   assign rc = ir_i[RC_MSB -: 4];

   // Gated fields are ORed, so asserting more than one gate merges bits
   assign reg_idx_o = ({4{gra_i}} & ra) | ({4{grb_i}} & rb) | ({4{grc_i}} & rc);

   always_comb begin
      rin_o = '0;
      if (rin_i) begin
         rin_o[reg_idx_o] = 1'b1;
      end
   end

   assign drive_o = rout_i | baout_i;
   // Base-address use of R0 means "no base": contributes zero
   assign zero_o  = baout_i & ~rout_i & (reg_idx_o == 4'd0);

endmodule

// File: rtl/datapath_p2.sv
// Phase-2 single-bus CPU datapath: register file, PC/IR/Y/Z/HI/LO/MAR/MDR,
// InPort/OutPort, priority bus mux, ALU, CON flag and a 512x32 RAM.
//   Clock  : system clock (rising edge)
//   Clear  : async active-low reset (RAM contents are not cleared)
//   bus_if : control strobes, Mdatain, InPort_in in; outp (OutPort) out
module datapath_p2
   import datapath_p2_pkg::*;
(
   input  logic           Clock,
   input  logic           Clear,
   datapath_p2_if.slave   bus_if
);

   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] pc_q, ir_q, y_q, zhi_q, zlo_q, hi_q, lo_q, mar_q, mdr_q;
   logic [DATA_W-1:0] inport_q, outport_q;
   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic              con_q;

   // ---------------------------------------------------------------- select/encode
   logic [3:0]          reg_idx;
   logic [NUM_REGS-1:0] rin_vec;
   logic                reg_drive, reg_zero;

   datapath_p2_select_encode u_sel (
      .ir_i     (ir_q[RA_MSB:RC_MSB-3]),
      .gra_i    (bus_if.Gra),
      .grb_i    (bus_if.Grb),
      .grc_i    (bus_if.Grc),
      .rin_i    (bus_if.Rin),
      .rout_i   (bus_if.Rout),
      .baout_i  (bus_if.BAout),
      .reg_idx_o(reg_idx),
      .rin_o    (rin_vec),
      .drive_o  (reg_drive),
      .zero_o   (reg_zero)
   );

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_rf
      datapath_p2_reg32 u_r (
         .clk_i (Clock),
         .rst_ni(Clear),
         .ld_i  (rin_vec[i]),
         .d_i   (bus),
         .q_o   (rf_q[i])
      );
   end

   // ---------------------------------------------------------------- bus mux
   bus_src_e bus_src;

   always_comb begin
      bus_src = SrcNone;
      if (reg_drive)             bus_src = SrcReg;
      else if (bus_if.HIout)     bus_src = SrcHi;
      else if (bus_if.LOout)     bus_src = SrcLo;
      else if (bus_if.Zhiout)    bus_src = SrcZhi;
      else if (bus_if.Zlowout)   bus_src = SrcZlo;
      else if (bus_if.PCout)     bus_src = SrcPc;
      else if (bus_if.MDRout)    bus_src = SrcMdr;
      else if (bus_if.InPortout) bus_src = SrcInPort;
      else if (bus_if.Cout)      bus_src = SrcC;
   end

   always_comb begin
      bus = '0;
      unique case (bus_src)
         SrcReg:    bus = reg_zero ? '0 : rf_q[reg_idx];
         SrcHi:     bus = hi_q;
         SrcLo:     bus = lo_q;
         SrcZhi:    bus = zhi_q;
         SrcZlo:    bus = zlo_q;
         SrcPc:     bus = pc_q;
         SrcMdr:    bus = mdr_q;
         SrcInPort: bus = inport_q;
         SrcC:      bus = sext_c(ir_q);
         default:   bus = '0;
      endcase
   end

   // ---------------------------------------------------------------- ALU
   logic [DATA_W-1:0] alu_lo;

   always_comb begin
      alu_lo = '0;
      if (bus_if.IncPC)       alu_lo = bus + 32'd1;
      else if (bus_if.ADD)    alu_lo = y_q + bus;
      else if (bus_if.SUB)    alu_lo = y_q - bus;
      else if (bus_if.AND_op) alu_lo = y_q & bus;
   end

   // ---------------------------------------------------------------- MDR source
   logic [DATA_W-1:0] mdr_d;

   always_comb begin
      mdr_d = bus;
      if (bus_if.Read) begin
         mdr_d = bus_if.ReadEn ? mem_q[mar_q[ADDR_W-1:0]] : bus_if.Mdatain;
      end
   end

   // ---------------------------------------------------------------- CON
   logic con_d;

   always_comb begin
      con_d = 1'b0;
      unique case (ir_q[CON_MSB -: 2])
         2'b00: con_d = (bus == '0);
         2'b01: con_d = (bus != '0);
         2'b10: con_d = ~bus[DATA_W-1];
         2'b11: con_d = bus[DATA_W-1];
         default: con_d = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         con_q <= 1'b0;
      end else if (bus_if.CONIn) begin
         con_q <= con_d;
      end
   end

   // ---------------------------------------------------------------- registers
   datapath_p2_reg32 u_pc (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.PCin), .d_i(bus), .q_o(pc_q)
   );
   datapath_p2_reg32 u_ir (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.IRin), .d_i(bus), .q_o(ir_q)
   );
   datapath_p2_reg32 u_y (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.Yin), .d_i(bus), .q_o(y_q)
   );
   // Z is 64 bits; the supported ops never produce an upper word
   datapath_p2_reg32 u_zhi (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.Zin), .d_i('0), .q_o(zhi_q)
   );
   datapath_p2_reg32 u_zlo (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.Zin), .d_i(alu_lo), .q_o(zlo_q)
   );
   datapath_p2_reg32 u_hi (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.HIin), .d_i(bus), .q_o(hi_q)
   );
   datapath_p2_reg32 u_lo (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.LOin), .d_i(bus), .q_o(lo_q)
   );
   datapath_p2_reg32 u_mar (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.MARin), .d_i(bus), .q_o(mar_q)
   );
   datapath_p2_reg32 u_mdr (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.MDRin), .d_i(mdr_d), .q_o(mdr_q)
   );
   datapath_p2_reg32 u_inport (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.Strobe), .d_i(bus_if.InPort_in),
      .q_o(inport_q)
   );
   datapath_p2_reg32 u_outport (
      .clk_i(Clock), .rst_ni(Clear), .ld_i(bus_if.OutPortin), .d_i(bus), .q_o(outport_q)
   );

   assign bus_if.outp = outport_q;

   // ---------------------------------------------------------------- RAM
   // Writes take MDR's pre-edge value, so Write+MDRin stores the old word
   always_ff @(posedge Clock) begin
      if (bus_if.Write) begin
         mem_q[mar_q[ADDR_W-1:0]] <= mdr_q;
      end
   end

   // Opcode bits and high address bits are not used by this datapath phase
   logic unused_bits;
   assign unused_bits = ^{ir_q[DATA_W-1:RA_MSB+1], mar_q[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_datapath_p2.sv
module tb_datapath_p2;
   import datapath_p2_pkg::*;

   logic clk;
   logic clear;
   int   checks;
   int   fails;

   datapath_p2_if dp_if ();

   datapath_p2 dut (
      .Clock (clk),
      .Clear (clear),
      .bus_if(dp_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clr_ctl();
      dp_if.PCout = 0; dp_if.Zhiout = 0; dp_if.Zlowout = 0; dp_if.MDRout = 0;
      dp_if.HIout = 0; dp_if.LOout = 0; dp_if.InPortout = 0;
      dp_if.MARin = 0; dp_if.Zin = 0; dp_if.PCin = 0; dp_if.MDRin = 0; dp_if.IRin = 0;
      dp_if.Yin = 0; dp_if.HIin = 0; dp_if.LOin = 0; dp_if.OutPortin = 0;
      dp_if.IncPC = 0; dp_if.SUB = 0; dp_if.AND_op = 0; dp_if.ADD = 0;
      dp_if.Read = 0; dp_if.Write = 0; dp_if.ReadEn = 0;
      dp_if.Gra = 0; dp_if.Grb = 0; dp_if.Grc = 0; dp_if.Rin = 0; dp_if.Rout = 0;
      dp_if.BAout = 0; dp_if.Cout = 0; dp_if.CONIn = 0; dp_if.Strobe = 0;
   endtask

   // Apply the currently set controls for one edge, then idle them
   task automatic tick();
      @(posedge clk);
      #1;
      clr_ctl();
   endtask

   task automatic mdr_load(input logic [31:0] v);
      dp_if.Mdatain = v; dp_if.Read = 1; dp_if.MDRin = 1;
      tick();
   endtask

   task automatic load_ir(input logic [31:0] v);
      mdr_load(v);
      dp_if.MDRout = 1; dp_if.IRin = 1;
      tick();
   endtask

   task automatic load_y(input logic [31:0] v);
      mdr_load(v);
      dp_if.MDRout = 1; dp_if.Yin = 1;
      tick();
   endtask

   task automatic test_reset();
      clear = 0;
      clr_ctl();
      dp_if.Mdatain = '0; dp_if.InPort_in = '0;
      #12;
      checks++; if (dut.pc_q !== 32'd0) begin
         fails++; $display("FAIL reset_pc got %h want %h", dut.pc_q, 32'd0); end
      checks++; if (dut.mar_q !== 32'd0) begin
         fails++; $display("FAIL reset_mar got %h want %h", dut.mar_q, 32'd0); end
      checks++; if (dut.zlo_q !== 32'd0 || dut.zhi_q !== 32'd0) begin
         fails++; $display("FAIL reset_z got %h_%h want 0", dut.zhi_q, dut.zlo_q); end
      checks++; if (dp_if.outp !== 32'd0) begin
         fails++; $display("FAIL reset_outp got %h want %h", dp_if.outp, 32'd0); end
      checks++; if (dut.con_q !== 1'b0) begin
         fails++; $display("FAIL reset_con got %b want 0", dut.con_q); end
      @(negedge clk);
      clear = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_ram_preload();
      mdr_load(32'd85);
      dp_if.MDRout = 1; dp_if.MARin = 1;
      tick();
      checks++; if (dut.mar_q !== 32'd85) begin
         fails++; $display("FAIL preload_mar got %0d want 85", dut.mar_q); end
      mdr_load(32'd15);
      dp_if.Write = 1;
      tick();
      checks++; if (dut.mem_q[85] !== 32'd15) begin
         fails++; $display("FAIL preload_ram85 got %0d want 15", dut.mem_q[85]); end
      // Read the word back through the ReadEn path
      dp_if.Mdatain = 32'hDEAD_BEEF; dp_if.Read = 1; dp_if.ReadEn = 1; dp_if.MDRin = 1;
      tick();
      checks++; if (dut.mdr_q !== 32'd15) begin
         fails++; $display("FAIL ram_readback got %0d want 15", dut.mdr_q); end
   endtask

   task automatic test_reg_load();
      load_ir(32'h0080_0000);
      mdr_load(32'd10);
      dp_if.MDRout = 1; dp_if.Gra = 1; dp_if.Rin = 1;
      tick();
      checks++; if (dut.rf_q[1] !== 32'd10) begin
         fails++; $display("FAIL regload_r1 got %0d want 10", dut.rf_q[1]); end
      load_ir(32'h0000_0000);
      dp_if.Gra = 1; dp_if.Rin = 1;
      tick();
      checks++; if (dut.rf_q[0] !== 32'd0) begin
         fails++; $display("FAIL regload_r0 got %0d want 0", dut.rf_q[0]); end
   endtask

   task automatic test_fetch();
      dp_if.PCout = 1; dp_if.MARin = 1; dp_if.IncPC = 1; dp_if.Zin = 1;
      tick();
      checks++; if (dut.mar_q !== 32'd0) begin
         fails++; $display("FAIL fetch_mar got %0d want 0", dut.mar_q); end
      checks++; if (dut.zlo_q !== 32'd1) begin
         fails++; $display("FAIL fetch_zlo got %0d want 1", dut.zlo_q); end
      dp_if.Zlowout = 1; dp_if.PCin = 1;
      tick();
      checks++; if (dut.pc_q !== 32'd1) begin
         fails++; $display("FAIL fetch_pc got %0d want 1", dut.pc_q); end
      load_ir(32'h1080_005A);
      checks++; if (dut.ir_q !== 32'h1080_005A) begin
         fails++; $display("FAIL fetch_ir got %h want 1080005a", dut.ir_q); end
   endtask

   task automatic test_store();
      dp_if.Grb = 1; dp_if.BAout = 1; dp_if.Yin = 1;
      tick();
      checks++; if (dut.y_q !== 32'd0) begin
         fails++; $display("FAIL st_y got %0d want 0", dut.y_q); end
      dp_if.Cout = 1; dp_if.ADD = 1; dp_if.Zin = 1;
      tick();
      checks++; if (dut.zlo_q !== 32'd90) begin
         fails++; $display("FAIL st_zlo got %0d want 90", dut.zlo_q); end
      dp_if.Zlowout = 1; dp_if.MARin = 1;
      tick();
      checks++; if (dut.mar_q !== 32'd90) begin
         fails++; $display("FAIL st_mar got %0d want 90", dut.mar_q); end
      dp_if.Gra = 1; dp_if.Rout = 1; dp_if.MDRin = 1;
      tick();
      checks++; if (dut.mdr_q !== 32'd10) begin
         fails++; $display("FAIL st_mdr got %0d want 10", dut.mdr_q); end
      dp_if.Write = 1;
      tick();
      checks++; if (dut.mem_q[90] !== 32'd10) begin
         fails++; $display("FAIL st_ram90 got %0d want 10", dut.mem_q[90]); end
      dp_if.Gra = 1; dp_if.Rout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'd10) begin
         fails++; $display("FAIL st_outp got %0d want 10", dp_if.outp); end
   endtask

   task automatic test_alu();
      load_y(32'd5);
      mdr_load(32'd7);
      dp_if.MDRout = 1; dp_if.SUB = 1; dp_if.Zin = 1;
      tick();
      checks++; if (dut.zlo_q !== 32'hFFFF_FFFE || dut.zhi_q !== 32'd0) begin
         fails++; $display("FAIL alu_sub got %h_%h want 0_fffffffe", dut.zhi_q, dut.zlo_q); end
      load_y(32'h0000_F0F0);
      mdr_load(32'h0000_FF00);
      dp_if.MDRout = 1; dp_if.AND_op = 1; dp_if.Zin = 1;
      tick();
      checks++; if (dut.zlo_q !== 32'h0000_F000) begin
         fails++; $display("FAIL alu_and got %h want 0000f000", dut.zlo_q); end
      load_y(32'hFFFF_FFFF);
      mdr_load(32'd1);
      dp_if.MDRout = 1; dp_if.ADD = 1; dp_if.Zin = 1;
      tick();
      checks++; if (dut.zlo_q !== 32'd0) begin
         fails++; $display("FAIL alu_add_wrap got %h want 0", dut.zlo_q); end
      mdr_load(32'h10);
      dp_if.MDRout = 1; dp_if.IncPC = 1; dp_if.SUB = 1; dp_if.Zin = 1;
      tick();
      checks++; if (dut.zlo_q !== 32'h11) begin
         fails++; $display("FAIL alu_incpc_override got %h want 11", dut.zlo_q); end
      dp_if.MDRout = 1; dp_if.ADD = 1;
      tick();
      checks++; if (dut.zlo_q !== 32'h11) begin
         fails++; $display("FAIL alu_no_zin got %h want 11", dut.zlo_q); end
      dp_if.MDRout = 1; dp_if.Zin = 1;
      tick();
      checks++; if (dut.zlo_q !== 32'd0) begin
         fails++; $display("FAIL alu_no_op got %h want 0", dut.zlo_q); end
   endtask

   task automatic test_con();
      load_ir(32'h0088_0000);
      dp_if.Gra = 1; dp_if.Rout = 1; dp_if.CONIn = 1;
      tick();
      checks++; if (dut.con_q !== 1'b1) begin
         fails++; $display("FAIL con_ne_r1 got %b want 1", dut.con_q); end
      dp_if.CONIn = 1;
      tick();
      checks++; if (dut.con_q !== 1'b0) begin
         fails++; $display("FAIL con_ne_zero got %b want 0", dut.con_q); end
      load_ir(32'h0018_0000);
      mdr_load(32'h8000_0000);
      dp_if.MDRout = 1; dp_if.CONIn = 1;
      tick();
      checks++; if (dut.con_q !== 1'b1) begin
         fails++; $display("FAIL con_neg got %b want 1", dut.con_q); end
      load_ir(32'h0010_0000);
      mdr_load(32'h8000_0000);
      dp_if.MDRout = 1; dp_if.CONIn = 1;
      tick();
      checks++; if (dut.con_q !== 1'b0) begin
         fails++; $display("FAIL con_pos got %b want 0", dut.con_q); end
   endtask

   task automatic test_baout_r0();
      load_ir(32'h0000_0000);
      mdr_load(32'd7);
      dp_if.MDRout = 1; dp_if.Gra = 1; dp_if.Rin = 1;
      tick();
      dp_if.Grb = 1; dp_if.Rout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'd7) begin
         fails++; $display("FAIL rout_r0 got %0d want 7", dp_if.outp); end
      dp_if.Grb = 1; dp_if.BAout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'd0) begin
         fails++; $display("FAIL baout_r0 got %0d want 0", dp_if.outp); end
      load_ir(32'h0000_8000);
      dp_if.Grc = 1; dp_if.BAout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'd10) begin
         fails++; $display("FAIL baout_rc_r1 got %0d want 10", dp_if.outp); end
   endtask

   task automatic test_write_same_edge();
      mdr_load(32'd100);
      dp_if.MDRout = 1; dp_if.MARin = 1;
      tick();
      mdr_load(32'h11);
      dp_if.Mdatain = 32'h22; dp_if.Read = 1; dp_if.MDRin = 1; dp_if.Write = 1;
      tick();
      checks++; if (dut.mem_q[100] !== 32'h11) begin
         fails++; $display("FAIL same_edge_ram got %h want 11", dut.mem_q[100]); end
      checks++; if (dut.mdr_q !== 32'h22) begin
         fails++; $display("FAIL same_edge_mdr got %h want 22", dut.mdr_q); end
   endtask

   task automatic test_bus_priority();
      load_ir(32'h0007_FFFF);
      dp_if.Cout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'hFFFF_FFFF) begin
         fails++; $display("FAIL c_sext got %h want ffffffff", dp_if.outp); end
      dp_if.InPort_in = 32'h0000_ABCD; dp_if.Strobe = 1;
      tick();
      dp_if.InPortout = 1; dp_if.Cout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'h0000_ABCD) begin
         fails++; $display("FAIL prio_inport_c got %h want 0000abcd", dp_if.outp); end
      dp_if.PCout = 1; dp_if.MDRout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'd1) begin
         fails++; $display("FAIL prio_pc_mdr got %h want 1", dp_if.outp); end
      dp_if.MDRout = 1; dp_if.HIin = 1;
      tick();
      dp_if.HIout = 1; dp_if.PCout = 1; dp_if.OutPortin = 1;
      tick();
      checks++; if (dp_if.outp !== 32'h0007_FFFF) begin
         fails++; $display("FAIL prio_hi_pc got %h want 0007ffff", dp_if.outp); end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      clear = 0;
      #1;
      checks++; if (dut.pc_q !== 32'd0 || dut.mar_q !== 32'd0) begin
         fails++; $display("FAIL areset_pc_mar got %h/%h want 0/0", dut.pc_q, dut.mar_q); end
      checks++; if (dut.zlo_q !== 32'd0 || dut.rf_q[1] !== 32'd0) begin
         fails++; $display("FAIL areset_z_r1 got %h/%h want 0/0", dut.zlo_q, dut.rf_q[1]); end
      checks++; if (dut.mem_q[90] !== 32'd10) begin
         fails++; $display("FAIL areset_ram90 got %0d want 10", dut.mem_q[90]); end
      #10;
      clear = 1;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_ram_preload();
      test_reg_load();
      test_fetch();
      test_store();
      test_alu();
      test_con();
      test_baout_r0();
      test_write_same_edge();
      test_bus_priority();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
